// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the free-running reference clock.
// Pulses pll_rst, waits for a synchronised lock with timeout, qualifies it as stable, then
// releases sys_rst. Lock loss in RUN re-sequences; MAX_RETRIES consecutive timeouts park in FAIL.
// Optional feature: define PLL_LOCK_LOSS_COUNT_EN to count RUN lock-loss events.
module pll_lock_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned CNT_W               = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             restart,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic [1:0]       retry_count,
    output logic [CNT_W-1:0] lock_loss_count
);

    localparam int unsigned PulseW   = $clog2(RST_PULSE_CYCLES + 1);
    localparam int unsigned TimeoutW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned StableW  = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [PulseW-1:0]   PulseLast   = PulseW'(RST_PULSE_CYCLES - 1);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [StableW-1:0]  StableLast  = StableW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]          MaxRetries  = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStabilize,
        StRun,
        StFail
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    locked_s;
    logic [PulseW-1:0]       pulse_cnt_q, pulse_cnt_d;
    logic [TimeoutW-1:0]     timeout_cnt_q, timeout_cnt_d;
    logic [StableW-1:0]      stable_cnt_q, stable_cnt_d;
    logic [1:0]              retry_q, retry_d, retry_inc;
    logic                    loss_event;
    logic                    pll_rst_q, sys_rst_q, ready_q, fail_q;

    assign locked_s  = sync_q[SYNC_STAGES-1];
    assign retry_inc = retry_q + 2'd1;

    // Synchroniser chain for the asynchronous lock indication.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // State, timers and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q       <= StResetPll;
            pulse_cnt_q   <= '0;
            timeout_cnt_q <= '0;
            stable_cnt_q  <= '0;
            retry_q       <= '0;
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pulse_cnt_q   <= pulse_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            stable_cnt_q  <= stable_cnt_d;
            retry_q       <= retry_d;
            // Outputs are decoded from the next state so they change on the transition edge.
            pll_rst_q     <= (state_d == StResetPll) || (state_d == StFail);
            sys_rst_q     <= (state_d != StRun);
            ready_q       <= (state_d == StRun);
            fail_q        <= (state_d == StFail);
        end
    end

    // Next-state logic; restart overrides every other event in the same cycle.
    always_comb begin
        state_d       = state_q;
        pulse_cnt_d   = pulse_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        stable_cnt_d  = stable_cnt_q;
        retry_d       = retry_q;
        loss_event    = 1'b0;
        if (restart) begin
            state_d     = StResetPll;
            pulse_cnt_d = '0;
            retry_d     = '0;
        end else begin
            unique case (state_q)
                StResetPll: begin
                    if (pulse_cnt_q == PulseLast) begin
                        state_d       = StWaitLock;
                        timeout_cnt_d = '0;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + PulseW'(1);
                    end
                end
                StWaitLock, StStabilize: begin
                    // Timeout spans both states and takes priority over lock progress.
                    if (timeout_cnt_q == TimeoutLast) begin
                        retry_d     = retry_inc;
                        pulse_cnt_d = '0;
                        state_d     = (retry_inc == MaxRetries) ? StFail : StResetPll;
                    end else begin
                        timeout_cnt_d = timeout_cnt_q + TimeoutW'(1);
                        if (state_q == StWaitLock) begin
                            if (locked_s) begin
                                state_d      = StStabilize;
                                stable_cnt_d = '0;
                            end
                        end else if (!locked_s) begin
                            state_d      = StWaitLock;
                            stable_cnt_d = '0;
                        end else if (stable_cnt_q == StableLast) begin
                            state_d = StRun;
                            retry_d = '0;
                        end else begin
                            stable_cnt_d = stable_cnt_q + StableW'(1);
                        end
                    end
                end
                StRun: begin
                    if (!locked_s) begin
                        state_d     = StResetPll;
                        pulse_cnt_d = '0;
                        loss_event  = 1'b1;
                    end
                end
                StFail: begin
                    state_d = StFail;
                end
                default: begin
                    state_d     = StResetPll;
                    pulse_cnt_d = '0;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [CNT_W-1:0] loss_cnt_q;

    // Saturating lock-loss counter; only rst clears it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else if (loss_event && (loss_cnt_q != '1)) begin
            loss_cnt_q <= loss_cnt_q + CNT_W'(1);
        end
    end

    assign lock_loss_count = loss_cnt_q;
`else
    logic unused_loss_event;
    assign unused_loss_event = loss_event;
    assign lock_loss_count   = '0;
`endif

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule
